// File: rtl/btn_sched_pkg.sv
// Shared types and width helpers for the push-button event scheduler.
package btn_sched_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } sched_state_e;

  localparam int MIN_CNT_W = 1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width that holds 0..max_val inclusive, so counters can saturate without wrapping.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : MIN_CNT_W;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_scheduler_channel.sv
// One button channel: debounce, press-edge detection and hold-to-repeat timing.
module btn_channel
  import btn_sched_pkg::*;
#(
  parameter int DEBOUNCE_PERIOD = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic evt_pulse,
  output logic evt_is_repeat
);

  localparam int DB_W   = cnt_w(DEBOUNCE_PERIOD);
  localparam int HOLD_W = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DB_W-1:0]   DB_MAX      = DB_W'(DEBOUNCE_PERIOD);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rep_phase_q, rep_phase_d;
  logic              pulse_q, pulse_d;
  logic              is_rep_q, is_rep_d;
  logic [HOLD_W-1:0] hold_last;

  always_comb begin
    db_cnt_d    = db_cnt_q;
    level_d     = level_q;
    hold_cnt_d  = hold_cnt_q;
    rep_phase_d = rep_phase_q;
    pulse_d     = 1'b0;
    is_rep_d    = is_rep_q;
    hold_last   = rep_phase_q ? PERIOD_LAST : DELAY_LAST;

    if (!btn_in) begin
      db_cnt_d = '0;
      level_d  = 1'b0;
    end else if (db_cnt_q == DB_MAX) begin
      level_d = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    // Hold timer runs only while the debounced level stays high; rep_phase picks delay vs period.
    if (!level_d) begin
      hold_cnt_d  = '0;
      rep_phase_d = 1'b0;
    end else if (!level_q) begin
      pulse_d     = 1'b1;
      is_rep_d    = 1'b0;
      hold_cnt_d  = '0;
      rep_phase_d = 1'b0;
    end else if (hold_cnt_q >= hold_last) begin
      pulse_d     = 1'b1;
      is_rep_d    = 1'b1;
      hold_cnt_d  = '0;
      rep_phase_d = 1'b1;
    end else begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
      pulse_q     <= 1'b0;
      is_rep_q    <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
      pulse_q     <= pulse_d;
      is_rep_q    <= is_rep_d;
    end
  end

  assign btn_level     = level_q;
  assign evt_pulse     = pulse_q;
  assign evt_is_repeat = is_rep_q;

endmodule

// File: rtl/btn_event_scheduler.sv
// Button front-end: per-channel pending/overrun tracking, round-robin arbitration
// and a valid/ready output FSM serialising press and repeat events.
module btn_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_PERIOD = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_input,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [id_w(NUM_BTN)-1:0]   evt_id,
  output logic                       evt_repeat,
  output logic [NUM_BTN-1:0]         ovr_flag,
  input  logic                       ovr_clr
);

  localparam int IDW = id_w(NUM_BTN);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] chan_pulse;
  logic [NUM_BTN-1:0] chan_is_rep;

  sched_state_e       state_q, state_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] pend_rep_q, pend_rep_d;
  logic [NUM_BTN-1:0] ovr_q, ovr_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     evt_id_q, evt_id_d;
  logic               evt_repeat_q, evt_repeat_d;
  logic               evt_valid_q, evt_valid_d;
  logic [IDW-1:0]     sel;
  logic               grant;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_PERIOD(DEBOUNCE_PERIOD),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .btn_in       (btn_input[i]),
      .btn_level    (btn_level[i]),
      .evt_pulse    (chan_pulse[i]),
      .evt_is_repeat(chan_is_rep[i])
    );
  end

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_BTN) sum = sum - NUM_BTN;
    return IDW'(sum);
  endfunction

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_rep_d   = pend_rep_q;
    rr_ptr_d     = rr_ptr_q;
    evt_id_d     = evt_id_q;
    evt_repeat_d = evt_repeat_q;
    evt_valid_d  = evt_valid_q;
    grant        = 1'b0;
    sel          = '0;

    // Scanning from the far end down leaves the first pending index at or after rr_ptr in sel.
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (pending_q[wrap_add(rr_ptr_q, k)]) sel = wrap_add(rr_ptr_q, k);
    end

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant          = 1'b1;
          evt_id_d       = sel;
          evt_repeat_d   = pend_rep_q[sel];
          evt_valid_d    = 1'b1;
          pending_d[sel] = 1'b0;
          state_d        = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = (evt_id_q == LAST_ID) ? '0 : evt_id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New events are applied after the grant so a same-cycle event re-arms the channel, and set beats clear.
    ovr_d = ovr_clr ? '0 : ovr_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (chan_pulse[i]) begin
        if (pending_q[i] && !(grant && (sel == IDW'(i)))) ovr_d[i] = 1'b1;
        pending_d[i]  = 1'b1;
        pend_rep_d[i] = chan_is_rep[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      pend_rep_q   <= '0;
      ovr_q        <= '0;
      rr_ptr_q     <= '0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      evt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_rep_q   <= pend_rep_d;
      ovr_q        <= ovr_d;
      rr_ptr_q     <= rr_ptr_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
      evt_valid_q  <= evt_valid_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign ovr_flag   = ovr_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed self-checking bench for btn_event_scheduler with short debounce/repeat timings.
module tb_btn_event_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_input;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] ovr_flag;
  logic       ovr_clr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_ids[$];
  int hs_reps[$];
  int hs_cycs[$];
  int base;
  logic [8:0] bounce_pat;

  btn_event_scheduler #(
    .NUM_BTN        (4),
    .DEBOUNCE_PERIOD(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_input (btn_input),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_repeat(evt_repeat),
    .ovr_flag  (ovr_flag),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change only at negedge+1, so at negedge valid&&ready means a handshake on the next posedge.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      hs_ids.push_back(int'(evt_id));
      hs_reps.push_back(int'(evt_repeat));
      hs_cycs.push_back(cyc);
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic rdy, input logic clr);
    btn_input = b;
    evt_ready = rdy;
    ovr_clr   = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(2);
    checkOutput("rst_level", btn_level, 0);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_id", evt_id, 0);
    checkOutput("rst_repeat", evt_repeat, 0);
    checkOutput("rst_ovr", ovr_flag, 0);
    reset = 1'b0;
    cycles(1);

    // Clean press on channel 2.
    base = hs_ids.size();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    cycles(4);
    checkOutput("t1_level_early", btn_level[2], 0);
    cycles(1);
    checkOutput("t1_level_rise", btn_level[2], 1);
    checkOutput("t1_valid_t", evt_valid, 0);
    cycles(1);
    checkOutput("t1_valid_t1", evt_valid, 0);
    cycles(1);
    checkOutput("t1_valid_t2", evt_valid, 1);
    checkOutput("t1_id", evt_id, 2);
    checkOutput("t1_repeat", evt_repeat, 0);
    cycles(3);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(2);
    checkOutput("t1_level_fall", btn_level[2], 0);
    checkOutput("t1_count", hs_ids.size() - base, 1);
    checkOutput("t1_hs_id", hs_ids[base], 2);

    // Bounce on channel 1: the low sample restarts the debounce count.
    base = hs_ids.size();
    bounce_pat = 9'b111110111;
    for (int j = 0; j < 9; j++) begin
      btn_input[1] = bounce_pat[j];
      cycles(1);
      if (j == 4) checkOutput("t2_level_after_glitch", btn_level[1], 0);
      if (j == 7) checkOutput("t2_level_4_highs", btn_level[1], 0);
    end
    checkOutput("t2_level_rise", btn_level[1], 1);
    cycles(2);
    checkOutput("t2_valid", evt_valid, 1);
    checkOutput("t2_id", evt_id, 1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(3);
    checkOutput("t2_count", hs_ids.size() - base, 1);
    checkOutput("t2_hs_id", hs_ids[base], 1);

    // Reset so the round-robin pointer starts at 0 for the simultaneous case.
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(1);

    base = hs_ids.size();
    applyStimulus(4'b1001, 1'b1, 1'b0);
    cycles(7);
    checkOutput("t3_first_valid", evt_valid, 1);
    checkOutput("t3_first_id", evt_id, 0);
    cycles(1);
    checkOutput("t3_bubble", evt_valid, 0);
    cycles(1);
    checkOutput("t3_second_valid", evt_valid, 1);
    checkOutput("t3_second_id", evt_id, 3);
    cycles(1);
    checkOutput("t3_done_valid", evt_valid, 0);
    checkOutput("t3_rr_ptr", dut.rr_ptr_q, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(3);
    checkOutput("t3_count", hs_ids.size() - base, 2);

    // Hold channel 1 for 60 cycles: press, repeat after 20, then every 8.
    base = hs_ids.size();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    cycles(60);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(4);
    checkOutput("t4_count", hs_ids.size() - base, 6);
    checkOutput("t4_press_rep", hs_reps[base], 0);
    for (int e = 1; e < 6; e++) begin
      checkOutput("t4_id", hs_ids[base + e], 1);
      checkOutput("t4_rep", hs_reps[base + e], 1);
      checkOutput("t4_gap", hs_cycs[base + e] - hs_cycs[base + e - 1], (e == 1) ? 20 : 8);
    end

    // Backpressure: outputs hold while the second repeat overruns the pending slot.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    cycles(7);
    checkOutput("t5_valid", evt_valid, 1);
    checkOutput("t5_id", evt_id, 1);
    checkOutput("t5_repeat", evt_repeat, 0);
    cycles(13);
    checkOutput("t5_hold_id", evt_id, 1);
    checkOutput("t5_hold_rep", evt_repeat, 0);
    cycles(13);
    checkOutput("t5_ovr_before", ovr_flag, 0);
    cycles(7);
    checkOutput("t5_ovr_set", ovr_flag, 4'b0010);
    checkOutput("t5_hold_valid", evt_valid, 1);
    checkOutput("t5_hold_id2", evt_id, 1);
    checkOutput("t5_hold_rep2", evt_repeat, 0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    cycles(1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    cycles(1);
    checkOutput("t5_ovr_clr", ovr_flag, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(1);
    checkOutput("t5_after_hs", evt_valid, 0);
    cycles(1);
    checkOutput("t5_pend_valid", evt_valid, 1);
    checkOutput("t5_pend_id", evt_id, 1);
    checkOutput("t5_pend_rep", evt_repeat, 1);
    cycles(1);
    checkOutput("t5_pend_done", evt_valid, 0);

    // Reset while an event is presented and channel 2 is held.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    cycles(7);
    checkOutput("t6_valid_pre", evt_valid, 1);
    checkOutput("t6_id_pre", evt_id, 2);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_valid", evt_valid, 0);
    checkOutput("t6_async_id", evt_id, 0);
    checkOutput("t6_async_level", btn_level, 0);
    checkOutput("t6_async_ovr", ovr_flag, 0);
    cycles(2);
    base = hs_ids.size();
    reset = 1'b0;
    evt_ready = 1'b1;
    cycles(4);
    checkOutput("t6_redebounce", btn_level[2], 0);
    cycles(1);
    checkOutput("t6_level", btn_level[2], 1);
    cycles(2);
    checkOutput("t6_valid", evt_valid, 1);
    checkOutput("t6_id", evt_id, 2);
    checkOutput("t6_repeat", evt_repeat, 0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    cycles(3);
    checkOutput("t6_count", hs_ids.size() - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
